// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants, init FSM states and lane helper for sync_ram_bwe
package ram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        CLEAR,
        READY
    } init_state_t;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_init_seq.sv
// rtl/ram_init_seq.sv - post-reset clear sequencer: walks every address once, then releases the port
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    init_state_t           state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        init_busy = 1'b0;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
                ptr_nxt   = ptr + ADDR_WIDTH'(1);
                if (ptr == LAST_ADDR) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                state_nxt = READY;
            end
        endcase
    end

    assign clr_addr = ptr;

endmodule

// File: rtl/sync_ram_bwe.sv
// rtl/sync_ram_bwe.sv - byte-enable simple-dual-port RAM; SYNC_RAM_OUT_REG_EN adds an output register stage
module sync_ram_bwe
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    RDW_MODE   = RDW_OLD,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              we,
    input  logic [lane_count(DATA_WIDTH)-1:0] be,
    input  logic [ADDR_WIDTH-1:0]             write_addr,
    input  logic [DATA_WIDTH-1:0]             data,
    input  logic                              re,
    input  logic [ADDR_WIDTH-1:0]             read_addr,
    output logic [DATA_WIDTH-1:0]             q,
    output logic                              q_valid,
    output logic                              init_busy
);

    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
            $error("sync_ram_bwe: DATA_WIDTH must be a non-zero multiple of 8");
        end
    endgenerate

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The clear sequencer owns the write port until it finishes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VALUE;
        end else if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[write_addr][8*i +: 8] <= data[8*i +: 8];
                end
            end
        end
    end

    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_word;

    assign rd_ok = re && !init_busy;

    // Write-first bypass: merge enabled lanes of the incoming write into the read word.
    always_comb begin
        rd_word = mem[read_addr];
        if (RDW_MODE == RDW_NEW && we && !init_busy && write_addr == read_addr) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    rd_word[8*i +: 8] = data[8*i +: 8];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] q_arr;
    logic                  v_arr;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_arr <= '0;
            v_arr <= 1'b0;
        end else begin
            v_arr <= rd_ok;
            if (rd_ok) begin
                q_arr <= rd_word;
            end
        end
    end

`ifdef SYNC_RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] q_out;
    logic                  v_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_out <= '0;
            v_out <= 1'b0;
        end else begin
            v_out <= v_arr;
            if (v_arr) begin
                q_out <= q_arr;
            end
        end
    end

    assign q       = q_out;
    assign q_valid = v_out;
`else
    assign q       = q_arr;
    assign q_valid = v_arr;
`endif

endmodule

// File: tb/tb_sync_ram_bwe.sv
// tb/tb_sync_ram_bwe.sv - randomized and directed bench for sync_ram_bwe, both read-during-write policies
module tb_sync_ram_bwe;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
`ifdef SYNC_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, we, re;
    logic [3:0]    be;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] data;
    logic [DW-1:0] q0, q1;
    logic          v0, v1, b0, b1;

    sync_ram_bwe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0)) dut_old (
        .clk(clk), .rst(rst), .we(we), .be(be), .write_addr(wa), .data(data),
        .re(re), .read_addr(ra), .q(q0), .q_valid(v0), .init_busy(b0)
    );

    sync_ram_bwe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1)) dut_new (
        .clk(clk), .rst(rst), .we(we), .be(be), .write_addr(wa), .data(data),
        .re(re), .read_addr(ra), .q(q1), .q_valid(v1), .init_busy(b1)
    );

    typedef struct {
        int          due;
        logic [31:0] val;
    } rd_t;

    logic [31:0] mm [DEPTH];
    rd_t         pq0[$];
    rd_t         pq1[$];
    logic [31:0] eq0 = '0;
    logic [31:0] eq1 = '0;
    int          busy_left = DEPTH;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] old;
        bit          act, ev0, ev1;
        old = '0;
        @(posedge clk);
        cyc++;
        if (rst) begin
            pq0.delete();
            pq1.delete();
            eq0 = '0;
            eq1 = '0;
            busy_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        end else begin
            act = (busy_left == 0);
            if (busy_left > 0) busy_left--;
            if (act && re) old = mm[ra];
            if (act && we)
                for (int l = 0; l < 4; l++)
                    if (be[l]) mm[wa][8*l +: 8] = data[8*l +: 8];
            if (act && re) begin
                pq0.push_back(rd_t'{due: cyc + LAT - 1, val: old});
                pq1.push_back(rd_t'{due: cyc + LAT - 1, val: mm[ra]});
            end
        end
        @(negedge clk);
        ev0 = (pq0.size() > 0) && (pq0[0].due == cyc);
        if (ev0) begin
            eq0 = pq0[0].val;
            void'(pq0.pop_front());
        end
        ev1 = (pq1.size() > 0) && (pq1[0].due == cyc);
        if (ev1) begin
            eq1 = pq1[0].val;
            void'(pq1.pop_front());
        end
        chk("init_busy_old", b0, busy_left > 0);
        chk("init_busy_new", b1, busy_left > 0);
        chk("q_valid_old", v0, ev0);
        chk("q_valid_new", v1, ev1);
        chk("q_old", q0, eq0);
        chk("q_new", q1, eq1);
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0;
        be = 'x; wa = 'x; ra = 'x; data = 'x;
    endtask

    task automatic wr(input logic [3:0] b, input logic [AW-1:0] a, input logic [31:0] d);
        we = 1'b1; be = b; wa = a; data = d;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        re = 1'b1; ra = a;
    endtask

    task automatic rand_access(input int amax);
        we = 1'($urandom); be = 4'($urandom); wa = AW'($urandom_range(amax)); data = $urandom;
        re = 1'($urandom); ra = AW'($urandom_range(amax));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick(); tick();
        rst = 1'b0;
        repeat (DEPTH) tick();
        chk("busy_done", b0, 1'b0);

        rd(6'h3F); tick(); idle(); tick(); tick();
        chk("after_clear_3f", q0, 32'h0);

        wr(4'hF, 6'h02, 32'h12); tick(); idle();
        rd(6'h02); tick(); idle(); tick(); tick();
        chk("basic_rd2", q0, 32'h12);
        rd(6'h03); tick(); idle(); tick(); tick();
        chk("basic_rd3", q0, 32'h0);

        wr(4'hF, 6'h05, 32'hAABBCCDD); tick();
        wr(4'h5, 6'h05, 32'h11223344); tick();
        wr(4'h0, 6'h05, 32'hFFFFFFFF); tick(); idle();
        rd(6'h05); tick(); idle(); tick(); tick();
        chk("byte_en_merge", q0, 32'hAA22CC44);

        wr(4'hF, 6'h07, 32'h34); tick(); idle();
        wr(4'hF, 6'h07, 32'h56); rd(6'h07); tick(); idle(); tick(); tick();
        chk("rdw_old_mode", q0, 32'h34);
        chk("rdw_new_mode", q1, 32'h56);
        rd(6'h07); tick(); idle(); tick(); tick();
        chk("rdw_after_old", q0, 32'h56);
        chk("rdw_after_new", q1, 32'h56);

        wr(4'hF, 6'd40, 32'hFF); tick(); idle();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rand_access(63); tick();
        end
        idle();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr(4'hF, 6'd40, $urandom); rd(6'd40); tick();
        end
        idle();
        rd(6'd40); tick(); idle(); tick(); tick();
        chk("reclear_addr40", q0, 32'h0);

        wr(4'hF, 6'h02, 32'h12); tick(); idle();
        rd(6'h02); tick(); rd(6'h03); tick(); rd(6'h02); tick();
        idle(); tick(); tick(); tick();
        chk("b2b_last", q0, 32'h12);

        for (int i = 0; i < 400; i++) begin
            rand_access(7);
            rst = ($urandom_range(199) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (DEPTH + 4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
